// File: rtl/axi_bigreg_initiator.sv
// axi_bigreg_initiator: writes a wide register as NWORDS AXI-lite word beats followed by a valid-flag beat.
module axi_bigreg_initiator #(
  parameter int DATA_WIDTH = 256,
  parameter int WORD_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_base_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic [31:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  busy
);
  localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int BW = $clog2(NWORDS + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B, FINISH} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_beat, w_beat;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_base, w_base;
  logic [DATA_WIDTH-1:0] r_data, w_src;
  logic [WORD_WIDTH-1:0] w_word;
  logic [1:0] r_done_resp, w_resp;
  logic r_aw_done, r_w_done, w_aw_hs, w_w_hs, w_load, w_last, w_timeout;
  assign cmd_ready = r_state == IDLE;
  assign awvalid = r_state == ADDR_DATA && !r_aw_done;
  assign wvalid = r_state == ADDR_DATA && !r_w_done;
  assign bready = r_state == WAIT_B;
  assign done = r_state == FINISH;
  assign busy = r_state != IDLE;
  assign done_resp = r_done_resp;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs = wvalid && wready;
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  // The first beat is loaded straight from the command inputs, later beats from the latched copy.
  assign w_src = cmd_ready ? cmd_data : r_data;
  assign w_base = cmd_ready ? cmd_base_addr : r_base;
  assign w_beat = cmd_ready ? '0 : r_beat + BW'(1);
  assign w_word = WORD_WIDTH'(w_src >> (int'(w_beat) * WORD_WIDTH));
  assign w_last = w_beat == BW'(NWORDS);
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_resp = r_done_resp;
    unique case (r_state)
      IDLE: if (cmd_valid) begin
        w_next = ADDR_DATA;
        w_load = 1'b1;
        w_resp = 2'b00;
      end
      ADDR_DATA: if (r_aw_done && r_w_done) w_next = WAIT_B;
        else if (w_timeout && !((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))) begin
          w_next = FINISH;
          w_resp = 2'b10;
        end
      WAIT_B: if (bvalid) begin
        if (bresp[1]) begin
          w_next = FINISH;
          w_resp = bresp;
        end else if (r_beat == BW'(NWORDS)) begin
          w_next = FINISH;
          w_resp = 2'b00;
        end else begin
          w_next = ADDR_DATA;
          w_load = 1'b1;
        end
      end else if (w_timeout) begin
        w_next = FINISH;
        w_resp = 2'b10;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_cnt <= '0;
      r_base <= '0;
      r_data <= '0;
      r_done_resp <= 2'b00;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
      awaddr <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else begin
      r_state <= w_next;
      r_done_resp <= w_resp;
      r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
      r_aw_done <= w_load ? 1'b0 : r_aw_done | w_aw_hs;
      r_w_done <= w_load ? 1'b0 : r_w_done | w_w_hs;
      if (w_load && cmd_ready) begin
        r_base <= cmd_base_addr;
        r_data <= cmd_data;
      end
      if (w_load) begin
        r_beat <= w_beat;
        awaddr <= w_base + (32'(w_beat) << 2);
        wdata <= w_last ? 32'h1 : 32'(w_word);
        wstrb <= 4'hF;
      end
    end
  end
endmodule
